// File: rtl/svga_timing.sv
`default_nettype none
// ============================================================================
//  Module      : svga_timing
//  Description : SVGA raster timing generator. Free-running horizontal and
//                vertical counters with registered sync, blanking, data-enable
//                and end-of-line / end-of-frame pulses, all aligned to the
//                counter values shown in the same cycle.
//                Optional macro SVGA_TIMING_CE_EN adds a pixel clock enable
//                input (pix_ce) that gates every counter advance.
//  Revision    : 1.0  initial release
// ============================================================================
module svga_timing #(
  parameter int H_VISIBLE = 800,
  parameter int H_FRONT   = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BACK    = 88,
  parameter int V_VISIBLE = 600,
  parameter int V_FRONT   = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BACK    = 23
) (
  input  logic        clk,
  input  logic        reset,
`ifdef SVGA_TIMING_CE_EN
  input  logic        pix_ce,
`endif
  output logic [10:0] hpos,
  output logic [9:0]  vpos,
  output logic        hsync,
  output logic        vsync,
  output logic        hblank,
  output logic        vblank,
  output logic        de,
  output logic        next_vertical,
  output logic        next_frame
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
  localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0]  VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  // running is low during reset and for the first cycle after it, so that
  // cycle loads the flags for position (0,0) without moving the counters.
  logic        running;
  logic        ce;
  logic        advance;
  logic [10:0] hpos_nxt;
  logic [9:0]  vpos_nxt;
  logic        line_end_q;
  logic        frame_end_q;

`ifdef SVGA_TIMING_CE_EN
  assign ce = pix_ce;
`else
  assign ce = 1'b1;
`endif

  assign advance = running & ce;

  // Next counter values; flags are decoded from these so they line up with
  // the counters they describe once both are registered.
  always_comb begin
    hpos_nxt = hpos;
    vpos_nxt = vpos;
    if (advance) begin
      if (hpos == H_LAST) begin
        hpos_nxt = 11'd0;
        vpos_nxt = (vpos == V_LAST) ? 10'd0 : 10'(vpos + 10'd1);
      end else begin
        hpos_nxt = 11'(hpos + 11'd1);
      end
    end
  end

  // Counter and flag registers; everything holds while the enable is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      running     <= 1'b0;
      hpos        <= 11'd0;
      vpos        <= 10'd0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      de          <= 1'b0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else if (!running || ce) begin
      running     <= 1'b1;
      hpos        <= hpos_nxt;
      vpos        <= vpos_nxt;
      hsync       <= (hpos_nxt >= HS_START) && (hpos_nxt < HS_END);
      vsync       <= (vpos_nxt >= VS_START) && (vpos_nxt < VS_END);
      hblank      <= (hpos_nxt >= H_VIS_END);
      vblank      <= (vpos_nxt >= V_VIS_END);
      de          <= (hpos_nxt < H_VIS_END) && (vpos_nxt < V_VIS_END);
      line_end_q  <= (hpos_nxt == H_LAST);
      frame_end_q <= (hpos_nxt == H_LAST) && (vpos_nxt == V_LAST);
    end
  end

`ifdef SVGA_TIMING_CE_EN
  // Pulses only count on cycles that actually advance.
  assign next_vertical = line_end_q & pix_ce;
  assign next_frame    = frame_end_q & pix_ce;
`else
  assign next_vertical = line_end_q;
  assign next_frame    = frame_end_q;
`endif

endmodule
`default_nettype wire
